ov_capture: RTL and testbench
=============================

OV_CAPTURE -- requirements
Module: ov_capture

Interface
REQ-001 Parameter WRST_CYCLES, default 8: width in clocks of the FIFO write-pointer reset pulse.
REQ-002 Parameter VS_MIN_CYCLES, default 24: number of consecutive identical synchronized samples before the filtered VSYNC level changes.
REQ-003 clk_24MHz  input  1: sole clock; all logic on rising edge.
REQ-004 rst  input  1: reset; one clock, asynchronous, active-high.
REQ-005 initialized  input  1: camera register setup complete; capture runs only while high.
REQ-006 vsync  input  1: sensor VSYNC, asynchronous to clk_24MHz; rising edge marks a frame boundary.
REQ-007 frame_read  input  1: reader status; high = reader idle, low = reader draining FIFO.
REQ-008 wen  output  1: FIFO write enable, active-high.
REQ-009 wrst  output  1: FIFO write-pointer reset, active-low.
REQ-010 new_frame  output  1: level; high = complete frame in FIFO, awaiting reader.
REQ-011 frame_cnt  output  8: frames handed to reader, wraps 255->0.
REQ-012 drop_cnt  output  8: VSYNC rising edges lost while reader busy, saturates at 255.

Function
REQ-013 vsync SHALL pass a 2-FF synchronizer, then a filter whose level flips only after VS_MIN_CYCLES consecutive samples of the opposite value.
REQ-014 vs_edge SHALL be a 1-cycle pulse on the clock after the filtered level goes 0->1.
REQ-015 FSM states SHALL be S_IDLE, S_SYNC, S_WRST, S_CAPT, S_HAND, S_DRAIN.
REQ-016 S_IDLE: wen=0, wrst=1, new_frame=0; when initialized=1 and frame_read=1, next state S_SYNC.
REQ-017 S_SYNC: wait for vs_edge; on vs_edge go to S_WRST.
REQ-018 S_WRST: wrst=0 for exactly WRST_CYCLES clocks, wen=0; then wrst=1 and go to S_CAPT.
REQ-019 S_CAPT: wen=1; on vs_edge, the next clock SHALL show wen=0, new_frame=1, frame_cnt+1, state S_HAND.
REQ-020 S_HAND: new_frame=1 until frame_read samples 0; then new_frame=0 the next clock and state S_DRAIN.
REQ-021 S_DRAIN: wait for frame_read=1, then go to S_SYNC; wen stays 0 throughout.
REQ-022 Each vs_edge in S_HAND or S_DRAIN SHALL increment drop_cnt (saturating), including an edge in the same cycle as a state exit.
REQ-023 vs_edge in S_IDLE or S_WRST SHALL be ignored and not counted.
REQ-024 frame_read changes in S_SYNC, S_WRST or S_CAPT SHALL be ignored.
REQ-025 If initialized falls in any state other than S_IDLE, the next clock SHALL be S_IDLE with wen=0, wrst=1, new_frame=0; counters hold.
REQ-026 wen and wrst=0 SHALL never be asserted in the same cycle.
REQ-027 All outputs SHALL be registered (glitch-free to FIFO pins).

Reset
REQ-028 While rst=1: state=S_IDLE, wen=0, wrst=1, new_frame=0, frame_cnt=0, drop_cnt=0, synchronizer FFs=0, filter level=0, filter counter=0.
REQ-029 Reset assertion mid-capture SHALL force outputs to reset values immediately, without waiting for a clock.

Structure
REQ-030 Package ov_pkg SHALL hold the state enumeration and the default values of WRST_CYCLES and VS_MIN_CYCLES.
REQ-031 Synchronizer, filter and edge detector SHALL form sub-module ov_vsync_filter (in: clk_24MHz, rst, vsync, out: vs_level, vs_edge).

Verification
REQ-032 initialized=1, frame_read=1, vsync rise -> 8 clocks wrst=0, then wen=1; second rise -> wen=0, new_frame=1, frame_cnt=1.
REQ-033 vsync high pulse of 10 clocks (<24) -> no vs_edge, state unchanged, wen unchanged.
REQ-034 new_frame=1, frame_read driven 0 -> new_frame=0 one clock later; 3 vsync rises before frame_read returns 1 -> drop_cnt=3, then S_SYNC.
REQ-035 initialized dropped while wen=1 -> next clock wen=0, wrst=1, new_frame=0; frame_cnt unchanged.
REQ-036 rst pulsed mid-S_WRST -> wrst=1 asynchronously, all counters 0.
REQ-037 256 complete handshakes -> frame_cnt wraps to 0; 300 dropped edges -> drop_cnt holds at 255.

Source files
------------

// File: rtl/ov_pkg.sv
// Shared types and default timing for the OV camera frame-capture controller.
package ov_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SYNC  = 3'd1,
      S_WRST  = 3'd2,
      S_CAPT  = 3'd3,
      S_HAND  = 3'd4,
      S_DRAIN = 3'd5
   } ov_state_e;

   localparam int OV_WRST_CYCLES_DEF   = 8;
   localparam int OV_VS_MIN_CYCLES_DEF = 24;

endpackage

// File: rtl/ov_vsync_filter.sv
// VSYNC conditioning: 2-FF synchronizer, persistence filter and rising-edge detect.
module ov_vsync_filter
   import ov_pkg::*;
#(
   parameter int VS_MIN_CYCLES = OV_VS_MIN_CYCLES_DEF
) (
   input  logic clk_24MHz,
   input  logic rst,
   input  logic vsync,
   output logic vs_level,
   output logic vs_edge
);

   localparam int              CW    = $clog2(VS_MIN_CYCLES + 1);
   localparam logic [CW-1:0]   LP_TC = CW'(VS_MIN_CYCLES - 1);

   logic          r_sync0;
   logic          r_sync1;
   logic          r_level;
   logic          r_level_d;
   logic [CW-1:0] r_cnt;

   // r_cnt counts consecutive samples disagreeing with r_level; the
   // VS_MIN_CYCLES-th such sample flips the level.
   always_ff @(posedge clk_24MHz or posedge rst) begin
      if (rst) begin
         r_sync0   <= 1'b0;
         r_sync1   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync0   <= vsync;
         r_sync1   <= r_sync0;
         r_level_d <= r_level;
         if (r_sync1 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == LP_TC) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign vs_level = r_level;
   assign vs_edge  = r_level & ~r_level_d;

endmodule

// File: rtl/ov_capture.sv
// Frame-capture sequencer between an OV camera and its frame FIFO.
// All FIFO-facing outputs are flops decoded from the next state.
//
//   state   | meaning
//   S_IDLE  | camera not configured or reader busy; FIFO untouched
//   S_SYNC  | armed, waiting for a frame boundary
//   S_WRST  | FIFO write pointer held in reset for WRST_CYCLES clocks
//   S_CAPT  | writing pixels until the next frame boundary
//   S_HAND  | frame complete, waiting for reader to start draining
//   S_DRAIN | reader draining, waiting for it to go idle
module ov_capture
   import ov_pkg::*;
#(
   parameter int WRST_CYCLES   = OV_WRST_CYCLES_DEF,
   parameter int VS_MIN_CYCLES = OV_VS_MIN_CYCLES_DEF
) (
   input  logic       clk_24MHz,
   input  logic       rst,
   input  logic       initialized,
   input  logic       vsync,
   input  logic       frame_read,
   output logic       wen,
   output logic       wrst,
   output logic       new_frame,
   output logic [7:0] frame_cnt,
   output logic [7:0] drop_cnt
);

   localparam int            WW           = $clog2(WRST_CYCLES + 1);
   localparam logic [WW-1:0] LP_WRST_LOAD = WW'(WRST_CYCLES - 1);

   ov_state_e     r_state;
   ov_state_e     w_state_nxt;
   logic [WW-1:0] r_wrst_cnt;
   logic [WW-1:0] w_wrst_cnt_nxt;
   logic [7:0]    r_frame_cnt;
   logic [7:0]    w_frame_cnt_nxt;
   logic [7:0]    r_drop_cnt;
   logic [7:0]    w_drop_cnt_nxt;
   logic          r_wen;
   logic          r_wrst;
   logic          r_new_frame;
   logic          w_vs_level;
   logic          w_vs_edge;
   logic          w_frame_edge;

   ov_vsync_filter #(
      .VS_MIN_CYCLES (VS_MIN_CYCLES)
   ) u_vsync_filter (
      .clk_24MHz (clk_24MHz),
      .rst       (rst),
      .vsync     (vsync),
      .vs_level  (w_vs_level),
      .vs_edge   (w_vs_edge)
   );

   assign w_frame_edge = w_vs_edge & w_vs_level;

   always_comb begin
      w_state_nxt     = r_state;
      w_wrst_cnt_nxt  = r_wrst_cnt;
      w_frame_cnt_nxt = r_frame_cnt;
      w_drop_cnt_nxt  = r_drop_cnt;
      if (!initialized) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (frame_read) w_state_nxt = S_SYNC;
            end
            S_SYNC: begin
               if (w_frame_edge) begin
                  w_state_nxt    = S_WRST;
                  w_wrst_cnt_nxt = LP_WRST_LOAD;
               end
            end
            S_WRST: begin
               if (r_wrst_cnt == '0) w_state_nxt = S_CAPT;
               else                  w_wrst_cnt_nxt = r_wrst_cnt - WW'(1);
            end
            S_CAPT: begin
               if (w_frame_edge) begin
                  w_state_nxt     = S_HAND;
                  w_frame_cnt_nxt = r_frame_cnt + 8'd1;
               end
            end
            S_HAND: begin
               if (w_frame_edge && r_drop_cnt != 8'hFF) w_drop_cnt_nxt = r_drop_cnt + 8'd1;
               if (!frame_read) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
               if (w_frame_edge && r_drop_cnt != 8'hFF) w_drop_cnt_nxt = r_drop_cnt + 8'd1;
               if (frame_read) w_state_nxt = S_SYNC;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_24MHz or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wrst_cnt  <= '0;
         r_frame_cnt <= 8'd0;
         r_drop_cnt  <= 8'd0;
         r_wen       <= 1'b0;
         r_wrst      <= 1'b1;
         r_new_frame <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wrst_cnt  <= w_wrst_cnt_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
         r_drop_cnt  <= w_drop_cnt_nxt;
         r_wen       <= (w_state_nxt == S_CAPT);
         r_wrst      <= (w_state_nxt != S_WRST);
         r_new_frame <= (w_state_nxt == S_HAND);
      end
   end

   assign wen       = r_wen;
   assign wrst      = r_wrst;
   assign new_frame = r_new_frame;
   assign frame_cnt = r_frame_cnt;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_ov_capture.sv
// Self-checking bench for ov_capture: directed scenarios plus random traffic,
// every cycle compared against a behavioural frame-handshake model.
`timescale 1ns/1ps
module tb_ov_capture;

   localparam int WRST_CYCLES   = 8;
   localparam int VS_MIN_CYCLES = 24;

   logic       clk_24MHz = 1'b0;
   logic       rst;
   logic       initialized;
   logic       vsync;
   logic       frame_read;
   logic       wen;
   logic       wrst;
   logic       new_frame;
   logic [7:0] frame_cnt;
   logic [7:0] drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   ov_capture #(
      .WRST_CYCLES   (WRST_CYCLES),
      .VS_MIN_CYCLES (VS_MIN_CYCLES)
   ) dut (
      .clk_24MHz   (clk_24MHz),
      .rst         (rst),
      .initialized (initialized),
      .vsync       (vsync),
      .frame_read  (frame_read),
      .wen         (wen),
      .wrst        (wrst),
      .new_frame   (new_frame),
      .frame_cnt   (frame_cnt),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk_24MHz = ~clk_24MHz;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model ----------------
   typedef enum int {P_OFF, P_ARM, P_CLEAR, P_WRITE, P_READY, P_BUSY} phase_t;

   phase_t m_phase;
   int     m_clear_left;
   int     m_frames;
   int     m_drops;
   bit     m_pipe0, m_pipe1;
   bit     m_lvl, m_lvl_prev;
   bit     m_win[$];

   task automatic model_reset();
      m_phase      = P_OFF;
      m_clear_left = 0;
      m_frames     = 0;
      m_drops      = 0;
      m_pipe0      = 1'b0;
      m_pipe1      = 1'b0;
      m_lvl        = 1'b0;
      m_lvl_prev   = 1'b0;
      m_win.delete();
   endtask

   // One rising clock edge with the inputs currently applied.
   task automatic model_clock();
      bit edge_now;
      bit all_diff;
      edge_now = m_lvl && !m_lvl_prev;
      if (!initialized) begin
         m_phase = P_OFF;
      end else begin
         case (m_phase)
            P_OFF:   if (frame_read) m_phase = P_ARM;
            P_ARM:   if (edge_now) begin m_phase = P_CLEAR; m_clear_left = WRST_CYCLES; end
            P_CLEAR: begin
               m_clear_left--;
               if (m_clear_left == 0) m_phase = P_WRITE;
            end
            P_WRITE: if (edge_now) begin m_phase = P_READY; m_frames = (m_frames + 1) % 256; end
            P_READY: begin
               if (edge_now && m_drops < 255) m_drops++;
               if (!frame_read) m_phase = P_BUSY;
            end
            P_BUSY: begin
               if (edge_now && m_drops < 255) m_drops++;
               if (frame_read) m_phase = P_ARM;
            end
            default: m_phase = P_OFF;
         endcase
      end
      // filtered level flips once the last VS_MIN_CYCLES synchronized samples all disagree with it
      m_lvl_prev = m_lvl;
      m_win.push_back(m_pipe1);
      if (m_win.size() > VS_MIN_CYCLES) void'(m_win.pop_front());
      if (m_win.size() == VS_MIN_CYCLES) begin
         all_diff = 1'b1;
         foreach (m_win[i]) if (m_win[i] == m_lvl) all_diff = 1'b0;
         if (all_diff) m_lvl = !m_lvl;
      end
      m_pipe1 = m_pipe0;
      m_pipe0 = vsync;
   endtask

   function automatic logic [18:0] exp_vec();
      return {m_phase == P_WRITE, m_phase != P_CLEAR, m_phase == P_READY,
              8'(m_frames), 8'(m_drops)};
   endfunction

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
         if (n_bad >= 50) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end
      end
   endtask

   function automatic logic pick(input int which);
      case (which)
         0:       return wen;
         1:       return wrst;
         default: return new_frame;
      endcase
   endfunction

   task automatic step();
      if (rst) model_reset();
      else     model_clock();
      @(posedge clk_24MHz);
      @(negedge clk_24MHz);
      check_val("outs", 32'({wen, wrst, new_frame, frame_cnt, drop_cnt}), 32'(exp_vec()));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_out(input string tag, input int which, input logic val, input int lim);
      int n;
      n = 0;
      while (pick(which) !== val && n < lim) begin
         step();
         n++;
      end
      check_val(tag, 32'(pick(which)), 32'(val));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int seg;
      rst = 1'b1; initialized = 1'b0; vsync = 1'b0; frame_read = 1'b1;
      model_reset();
      run(2);
      check_val("rst_wen",   32'(wen),       32'd0);
      check_val("rst_wrst",  32'(wrst),      32'd1);
      check_val("rst_nf",    32'(new_frame), 32'd0);
      check_val("rst_fcnt",  32'(frame_cnt), 32'd0);
      check_val("rst_dcnt",  32'(drop_cnt),  32'd0);

      // first frame: write-pointer reset width then capture
      rst = 1'b0; initialized = 1'b1;
      run(3);
      vsync = 1'b1;
      wait_out("wrst_low", 1, 1'b0, 40);
      k = 0;
      while (wrst == 1'b0 && k < 20) begin step(); k++; end
      check_val("wrst_width", 32'(k), 32'(WRST_CYCLES));
      check_val("wen_on", 32'(wen), 32'd1);
      run(5);
      vsync = 1'b0; run(30);

      // short VSYNC glitch is filtered out
      vsync = 1'b1; run(10);
      vsync = 1'b0; run(30);
      check_val("glitch_wen", 32'(wen), 32'd1);
      check_val("glitch_nf",  32'(new_frame), 32'd0);

      // second boundary closes the frame
      vsync = 1'b1;
      wait_out("nf_on", 2, 1'b1, 40);
      check_val("close_wen",  32'(wen), 32'd0);
      check_val("close_fcnt", 32'(frame_cnt), 32'd1);
      run(5);
      vsync = 1'b0; run(30);

      // reader drains; boundaries meanwhile are counted as drops
      frame_read = 1'b0; step();
      check_val("drain_nf", 32'(new_frame), 32'd0);
      for (int i = 0; i < 3; i++) begin
         vsync = 1'b1; run(30);
         vsync = 1'b0; run(30);
      end
      check_val("drop3", 32'(drop_cnt), 32'd3);
      frame_read = 1'b1; step();
      vsync = 1'b1;
      wait_out("resync_wrst", 1, 1'b0, 40);
      wait_out("resync_wen", 0, 1'b1, 20);

      // configuration lost mid-capture
      initialized = 1'b0; step();
      check_val("uninit_wen",  32'(wen), 32'd0);
      check_val("uninit_wrst", 32'(wrst), 32'd1);
      check_val("uninit_nf",   32'(new_frame), 32'd0);
      check_val("uninit_fcnt", 32'(frame_cnt), 32'd1);
      check_val("uninit_dcnt", 32'(drop_cnt), 32'd3);
      initialized = 1'b1; step();
      vsync = 1'b0; run(30);

      // asynchronous reset during write-pointer reset
      vsync = 1'b1;
      wait_out("wrst_low2", 1, 1'b0, 40);
      run(2);
      rst = 1'b1;
      #1;
      model_reset();
      check_val("arst_wrst", 32'(wrst), 32'd1);
      check_val("arst_wen",  32'(wen), 32'd0);
      check_val("arst_fcnt", 32'(frame_cnt), 32'd0);
      check_val("arst_dcnt", 32'(drop_cnt), 32'd0);
      vsync = 1'b0;
      step();
      rst = 1'b0;
      run(30);

      // 256 complete handshakes: frame counter wraps
      for (int i = 0; i < 256; i++) begin
         vsync = 1'b1;
         wait_out("hs_wen", 0, 1'b1, 60);
         vsync = 1'b0; run(28);
         vsync = 1'b1;
         wait_out("hs_nf", 2, 1'b1, 60);
         check_val("hs_fcnt", 32'(frame_cnt), 32'((i + 1) % 256));
         frame_read = 1'b0; step();
         frame_read = 1'b1; step();
         vsync = 1'b0; run(28);
      end
      check_val("fcnt_wrap", 32'(frame_cnt), 32'd0);

      // reader never starts: 300 lost boundaries saturate the drop counter
      vsync = 1'b1;
      wait_out("sat_wen", 0, 1'b1, 60);
      vsync = 1'b0; run(28);
      vsync = 1'b1;
      wait_out("sat_nf", 2, 1'b1, 60);
      vsync = 1'b0; run(28);
      for (int i = 0; i < 300; i++) begin
         vsync = 1'b1; run(28);
         vsync = 1'b0; run(28);
         check_val("drop_sat", 32'(drop_cnt), 32'((i + 1 < 255) ? i + 1 : 255));
      end
      check_val("sat_nf_hold", 32'(new_frame), 32'd1);

      // random traffic against the model
      seg = 0;
      for (int i = 0; i < 5000; i++) begin
         if (seg == 0) begin
            vsync = ~vsync;
            seg = $urandom_range(3, 50);
         end
         seg--;
         if ($urandom_range(0, 15) == 0) frame_read = ~frame_read;
         initialized = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
